// File: rtl/axi_rd_slave_sram_if.sv
// AXI4 read-channel bundle (AR + R) between interconnect master and SRAM read slave.
// Signal names follow the AXI channel names so the slave's port map reads like the bus.
interface axi_rd_slave_sram_if #(
  parameter int ID_W  = 8,
  parameter int LEN_W = 4
);
  logic [ID_W-1:0]  ARID;
  logic [31:0]      ARADDR;
  logic [LEN_W-1:0] ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic             ARVALID;
  logic             ARREADY;

  logic [ID_W-1:0]  RID;
  logic [31:0]      RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_rd_slave_sram.sv
// AXI4 read-only responder in front of a synchronous single-port SRAM; one burst in flight.
// Optional beat counter on rd_beats when AXI_RD_SLV_PERF_EN is defined (tied to zero otherwise).
module axi_rd_slave_sram #(
  parameter int ID_W    = 8,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  axi_rd_slave_sram_if.slave bus,
  output logic               SRAM_CEB,
  output logic               SRAM_WEB,
  output logic [SRAM_AW-1:0] SRAM_A,
  input  logic [31:0]        SRAM_DO,
  output logic [31:0]        rd_beats
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Control state (reset)
  state_t             r_state;
  logic               r_arready;
  logic               r_rvalid;
  logic               r_rlast;
  logic [ID_W-1:0]    r_rid;
  logic [1:0]         r_rresp;
  logic               r_ceb;
  logic [LEN_W-1:0]   r_cnt;

  // Burst context (no reset, only meaningful after an AR handshake)
  logic [ID_W-1:0]    r_id_lat;
  logic [SRAM_AW-1:0] r_addr;
  logic [LEN_W-1:0]   r_len;
  logic               r_fixed;
  logic               r_err;

  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_ar_err;
  logic               w_unused_addr;

  function automatic logic [SRAM_AW-1:0] f_next_addr(input logic [SRAM_AW-1:0] addr,
                                                     input logic               fixed);
    f_next_addr = fixed ? addr : addr + 1'b1;
  endfunction

  assign bus.ARREADY = r_arready & rst;
  assign bus.RVALID  = r_rvalid;
  assign bus.RLAST   = r_rlast;
  assign bus.RID     = r_rid;
  assign bus.RRESP   = r_rresp;
  // SRAM_DO holds until the next access, so RDATA stays stable under backpressure
  assign bus.RDATA   = r_err ? 32'h0 : SRAM_DO;

  assign SRAM_CEB = r_ceb;
  assign SRAM_WEB = 1'b1;
  assign SRAM_A   = r_addr;

  assign w_ar_hs  = bus.ARVALID & bus.ARREADY;
  assign w_r_hs   = r_rvalid & bus.RREADY;
  assign w_ar_err = (bus.ARSIZE != 3'b010) || bus.ARBURST[1];

  assign w_unused_addr = ^{bus.ARADDR[31:SRAM_AW+2], bus.ARADDR[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_ceb     <= 1'b1;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_cnt     <= '0;
            r_ceb     <= w_ar_err;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_ceb    <= 1'b1;
          r_rvalid <= 1'b1;
          r_rlast  <= (r_cnt == r_len);
          r_rid    <= r_id_lat;
          r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_ceb   <= r_err;
              r_state <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Burst context capture and per-beat address advance
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_id_lat <= bus.ARID;
      r_addr   <= bus.ARADDR[SRAM_AW+1:2];
      r_len    <= bus.ARLEN;
      r_fixed  <= (bus.ARBURST == 2'b00);
      r_err    <= w_ar_err;
    end else if ((r_state == ST_RESP) && w_r_hs && !r_rlast) begin
      r_addr <= f_next_addr(r_addr, r_fixed);
    end
  end

`ifdef AXI_RD_SLV_PERF_EN
  logic [31:0] r_rd_beats;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    f_sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_beats <= '0;
    end else if (w_r_hs) begin
      r_rd_beats <= f_sat_inc(r_rd_beats);
    end
  end

  assign rd_beats = r_rd_beats;
`else
  assign rd_beats = 32'h0;
`endif

endmodule

// File: tb/tb_axi_rd_slave_sram.sv
// Directed bench for axi_rd_slave_sram: single/burst reads, backpressure, errors, FIXED/wrap, reset abort.
module tb_axi_rd_slave_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sram_ceb;
  logic        sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_do = 32'h0;
  logic [31:0] rd_beats;

  logic [31:0] mem [0:16383];
  logic [13:0] acc_a [0:255];
  int          acc_n = 0;
  logic [31:0] exp_d [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_slave_sram_if #(.ID_W(8), .LEN_W(4)) bus ();

  axi_rd_slave_sram #(.ID_W(8), .LEN_W(4), .SRAM_AW(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_CEB (sram_ceb),
    .SRAM_WEB (sram_web),
    .SRAM_A   (sram_a),
    .SRAM_DO  (sram_do),
    .rd_beats (rd_beats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_ceb) begin
      sram_do <= mem[sram_a];
      if (acc_n < 256) acc_a[acc_n] = sram_a;
      acc_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_ready_wait", {31'h0, bus.ARREADY}, 32'h1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic get_beat(output logic [31:0] d, output logic [1:0] r, output logic l,
                          output logic [7:0] id, output int w);
    w = 0;
    while (!bus.RVALID && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    d  = bus.RDATA;
    r  = bus.RRESP;
    l  = bus.RLAST;
    id = bus.RID;
    @(posedge clk); #1;
  endtask

  task automatic check_burst(input string tag, input logic [7:0] id, input int nb,
                             input logic [1:0] resp);
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [7:0]  i;
    int          w;
    for (int b = 0; b < nb; b++) begin
      get_beat(d, r, l, i, w);
      chk($sformatf("%s_lat%0d", tag, b), w, 32'd1);
      chk($sformatf("%s_data%0d", tag, b), d, exp_d[b]);
      chk($sformatf("%s_resp%0d", tag, b), {30'h0, r}, {30'h0, resp});
      chk($sformatf("%s_last%0d", tag, b), {31'h0, l}, {31'h0, (b == nb - 1)});
      chk($sformatf("%s_id%0d", tag, b), {24'h0, i}, {24'h0, id});
    end
    chk({tag, "_arready"}, {31'h0, bus.ARREADY}, 32'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [7:0]  i;
    int          w;
    int          a0;
    logic [31:0] hold_d;

    for (int k = 0; k < 16384; k++) mem[k] = 32'h5A00_0000 | k;
    mem[14'h10]   = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) mem[14'h40 + k] = 32'h1000_0000 + k;
    mem[14'h80]   = 32'hAAAA_0001;
    mem[14'h81]   = 32'hAAAA_0002;
    mem[14'h2]    = 32'h2222_2222;
    mem[14'h3]    = 32'h3333_3333;
    mem[14'h3FFF] = 32'h3FFF_3FFF;
    mem[14'h0]    = 32'h0000_0ABC;

    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'b010;
    bus.ARBURST = 2'b01; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid",  {31'h0, bus.RVALID},  32'h0);
    chk("rst_arready", {31'h0, bus.ARREADY}, 32'h0);
    chk("rst_rlast",   {31'h0, bus.RLAST},   32'h0);
    chk("rst_rid",     {24'h0, bus.RID},     32'h0);
    chk("rst_rresp",   {30'h0, bus.RRESP},   32'h0);
    chk("rst_ceb",     {31'h0, sram_ceb},    32'h1);
    chk("rst_web",     {31'h0, sram_web},    32'h1);
    chk("rst_beats",   rd_beats,             32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_arready", {31'h0, bus.ARREADY}, 32'h1);

    // Single read
    ar_send(8'h05, 32'h40, 4'd0, 3'b010, 2'b01);
    chk("single_fetch_rvalid", {31'h0, bus.RVALID}, 32'h0);
    chk("single_fetch_ceb",    {31'h0, sram_ceb},   32'h0);
    chk("single_fetch_addr",   {18'h0, sram_a},     32'h10);
    exp_d[0] = 32'hDEAD_BEEF;
    check_burst("single", 8'h05, 1, 2'b00);
`ifdef AXI_RD_SLV_PERF_EN
    chk("single_beats", rd_beats, 32'd1);
`else
    chk("single_beats", rd_beats, 32'd0);
`endif

    // INCR burst of 4
    a0 = acc_n;
    ar_send(8'h21, 32'h100, 4'd3, 3'b010, 2'b01);
    for (int k = 0; k < 4; k++) exp_d[k] = 32'h1000_0000 + k;
    check_burst("incr", 8'h21, 4, 2'b00);
    chk("incr_nacc", acc_n - a0, 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("incr_addr%0d", k), {18'h0, acc_a[a0 + k]}, 32'h40 + k);

    // Backpressure on beat 2
    ar_send(8'h33, 32'h200, 4'd1, 3'b010, 2'b01);
    get_beat(d, r, l, i, w);
    chk("bp_d0", d, 32'hAAAA_0001);
    bus.RREADY = 1'b0;
    @(posedge clk); #1;
    chk("bp_rvalid", {31'h0, bus.RVALID}, 32'h1);
    hold_d = bus.RDATA;
    chk("bp_d1", hold_d, 32'hAAAA_0002);
    chk("bp_last", {31'h0, bus.RLAST}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_v%0d", k), {31'h0, bus.RVALID}, 32'h1);
      chk($sformatf("bp_hold_d%0d", k), bus.RDATA, hold_d);
      chk($sformatf("bp_hold_l%0d", k), {31'h0, bus.RLAST}, 32'h1);
      chk($sformatf("bp_hold_ceb%0d", k), {31'h0, sram_ceb}, 32'h1);
    end
    bus.RREADY = 1'b1;
    get_beat(d, r, l, i, w);
    chk("bp_wait", w, 32'd0);
    chk("bp_final_d", d, 32'hAAAA_0002);
    chk("bp_arready", {31'h0, bus.ARREADY}, 32'h1);

    // Error bursts: bad size, then WRAP
    exp_d[0] = 32'h0; exp_d[1] = 32'h0;
    a0 = acc_n;
    ar_send(8'h44, 32'h40, 4'd1, 3'b001, 2'b01);
    check_burst("err_size", 8'h44, 2, 2'b10);
    chk("err_size_nacc", acc_n - a0, 32'd0);
    a0 = acc_n;
    ar_send(8'h45, 32'h40, 4'd1, 3'b010, 2'b10);
    check_burst("err_wrap", 8'h45, 2, 2'b10);
    chk("err_wrap_nacc", acc_n - a0, 32'd0);

    // FIXED burst
    a0 = acc_n;
    ar_send(8'h55, 32'h8, 4'd2, 3'b010, 2'b00);
    for (int k = 0; k < 3; k++) exp_d[k] = 32'h2222_2222;
    check_burst("fixed", 8'h55, 3, 2'b00);
    chk("fixed_nacc", acc_n - a0, 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("fixed_addr%0d", k), {18'h0, acc_a[a0 + k]}, 32'h2);

    // INCR wrap at top of SRAM, upper address bits ignored
    a0 = acc_n;
    ar_send(8'h66, 32'hA000_FFFC, 4'd1, 3'b010, 2'b01);
    exp_d[0] = 32'h3FFF_3FFF; exp_d[1] = 32'h0000_0ABC;
    check_burst("wrap_top", 8'h66, 2, 2'b00);
    chk("wrap_top_a0", {18'h0, acc_a[a0]},     32'h3FFF);
    chk("wrap_top_a1", {18'h0, acc_a[a0 + 1]}, 32'h0);

    // Reset during beat 2 of an 8-beat burst
    ar_send(8'h77, 32'h300, 4'd7, 3'b010, 2'b01);
    get_beat(d, r, l, i, w);
    chk("rmb_d0", d, mem[14'hC0]);
    bus.RREADY = 1'b0;
    @(posedge clk); #1;
    chk("rmb_beat2_valid", {31'h0, bus.RVALID}, 32'h1);
`ifdef AXI_RD_SLV_PERF_EN
    chk("rmb_beats_pre", rd_beats, 32'd17);
`else
    chk("rmb_beats_pre", rd_beats, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rmb_rvalid",  {31'h0, bus.RVALID},  32'h0);
    chk("rmb_arready", {31'h0, bus.ARREADY}, 32'h0);
    chk("rmb_ceb",     {31'h0, sram_ceb},    32'h1);
    chk("rmb_beats",   rd_beats,             32'h0);
    rst = 1'b1;
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    chk("rmb_rel_arready", {31'h0, bus.ARREADY}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rmb_quiet%0d", k), {31'h0, bus.RVALID}, 32'h0);
    end
    ar_send(8'h05, 32'h40, 4'd0, 3'b010, 2'b01);
    exp_d[0] = 32'hDEAD_BEEF;
    check_burst("post_rst", 8'h05, 1, 2'b00);
`ifdef AXI_RD_SLV_PERF_EN
    chk("post_rst_beats", rd_beats, 32'd1);
`else
    chk("post_rst_beats", rd_beats, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
